fifo_drain: RTL and testbench

Read-side master for the synchronous FIFO: watches `empty`, issues `rd_en`, captures the registered `data_out` and presents it on a valid/ready stream to downstream logic. Sits between the FIFO's read port and any consumer that may apply backpressure. Guarantees no read is issued on an empty FIFO and that no word is lost or duplicated under arbitrary `m_ready` patterns.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_drain_skid.sv | 51 +++++
 rtl/fifo_drain.sv | 85 ++++++++
 tb/tb_fifo_drain.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side drain master.
package fifo_pkg;
    localparam int FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;
endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry in-order skid buffer; entry 0 is always the head of the stream.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] entry0_p1;
    logic [WIDTH-1:0] entry1_p1;
    logic [1:0]       occ_p1;

    // Callers guarantee no push when full and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_p1 <= '0;
            entry1_p1 <= '0;
            occ_p1    <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_p1 == 2'd0) entry0_p1 <= din;
                    else                entry1_p1 <= din;
                    occ_p1 <= occ_p1 + 2'd1;
                end
                2'b01: begin
                    entry0_p1 <= entry1_p1;
                    occ_p1    <= occ_p1 - 2'd1;
                end
                2'b11: begin
                    if (occ_p1 == 2'd2) begin
                        entry0_p1 <= entry1_p1;
                        entry1_p1 <= din;
                    end else begin
                        entry0_p1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = entry0_p1;
    assign occ  = occ_p1;
endmodule

// File: rtl/fifo_drain.sv
// Read-side master for the synchronous FIFO: issues reads, captures the
// registered read data into a skid buffer and presents it as a valid/ready stream.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow
);
    drain_state_e   state, state_nxt;
    logic           vld_p1;
    logic [1:0]     occ;
    logic           pop;
    logic           push;
    logic [2:0]     load;
    logic [CNT_WIDTH-1:0] rd_count_p1;
    logic           err_p1;

    assign pop  = m_valid && m_ready;
    assign push = vld_p1 && !fifo_underflow;
    assign load = {1'b0, occ} + {2'b00, vld_p1};

    // Issue only if the word will have a skid slot once this cycle's pop drains.
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (load < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (enable) state_nxt = RUN;
            RUN:   if (!enable) state_nxt = FLUSH;
            FLUSH: begin
                if (enable)                             state_nxt = RUN;
                else if (!vld_p1 && (occ == 2'd0))      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 1: read issued last cycle, FIFO data_out/underflow valid now.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            rd_count_p1 <= '0;
            err_p1      <= 1'b0;
        end else begin
            vld_p1 <= fifo_rd_en;
            if (pop)                      rd_count_p1 <= rd_count_p1 + 1'b1;
            if (vld_p1 && fifo_underflow) err_p1      <= 1'b1;
        end
    end

    // Stage 2: skid buffer feeding the output stream.
    fifo_drain_skid #(.WIDTH(FIFO_WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (fifo_data_out),
        .pop  (pop),
        .head (m_data),
        .occ  (occ)
    );

    assign m_valid       = (occ != 2'd0);
    assign busy          = (state != IDLE);
    assign rd_count      = rd_count_p1;
    assign err_underflow = err_p1;
endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain driving a behavioural FIFO read port.
module tb_fifo_drain;
    import fifo_pkg::*;

    localparam int W  = FIFO_WIDTH;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_underflow = 1'b0;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          busy;
    logic [CW-1:0] rd_count;
    logic          err_underflow;

    always #5 clk = ~clk;

    fifo_drain #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .busy           (busy),
        .rd_count       (rd_count),
        .err_underflow  (err_underflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_pulses = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural FIFO: registered read data, underflow one cycle after rd_en.
    logic [W-1:0] mem [0:63];
    logic [5:0]   wr_ptr = '0;
    logic [5:0]   rd_ptr = '0;
    logic         clr = 1'b0;
    logic         uf_next = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        fifo_underflow <= fifo_rd_en && (fifo_empty || uf_next);
        if (clr) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 6'd1;
        end
    end

    // Independent occupancy model used for the read-issue rules.
    int   m_occ = 0;
    logic m_infl = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_occ  <= 0;
            m_infl <= 1'b0;
        end else begin
            m_occ  <= m_occ + ((m_infl && !fifo_underflow) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            m_infl <= fifo_rd_en;
        end
    end

    logic         stall_prev = 1'b0;
    logic [W-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            int pop_i;
            logic [W-1:0] e;
            pop_i = (m_valid && m_ready) ? 1 : 0;
            check("valid_vs_occ", {31'd0, m_valid}, {31'd0, (m_occ != 0)});
            if (fifo_rd_en) begin
                rd_pulses++;
                check("rd_on_empty", {31'd0, fifo_empty}, 32'd0);
                check("rd_when_full", {31'd0, ((m_occ + int'(m_infl) - pop_i) < 2)}, 32'd1);
            end
            if (stall_prev) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {16'd0, m_data}, {16'd0, hold_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", m_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", {16'd0, m_data}, {16'd0, e});
                end
            end
            stall_prev = m_valid && !m_ready;
            hold_data  = m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w, input bit expect_out);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr = 1'b1;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < maxc) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, (exp_q.size() == 0 && !m_valid)}, 32'd1);
    endtask

    task automatic wait_rd_en(input string name);
        int k = 0;
        @(negedge clk);
        while (!fifo_rd_en && k < 30) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, fifo_rd_en}, 32'd1);
    endtask

    initial begin
        int base, t0, k;
        int rd_n, rd_first, rd_last, v_n, v_first, v_last;

        // Reset state
        tick(3);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {16'd0, m_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_count", {16'd0, rd_count}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Single word latency
        load(16'hA001, 1'b1);
        m_ready = 1'b1;
        enable  = 1'b1;
        base = rd_pulses;
        wait_rd_en("single_rd_seen");
        t0 = cyc;
        k = 0;
        while (!m_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("single_latency", cyc - t0, 32'd2);
        tick(1);
        wait_drain("single_drain", 20);
        check("single_rd_pulses", rd_pulses - base, 32'd1);
        check("single_rd_count", {16'd0, rd_count}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);

        // Eight words at full throughput
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) load(W'(i), 1'b1);
        enable = 1'b1;
        wait_rd_en("burst_rd_seen");
        rd_n = 0; v_n = 0; rd_first = 0; rd_last = 0; v_first = 0; v_last = 0;
        for (int i = 0; i < 16; i++) begin
            if (fifo_rd_en) begin
                if (rd_n == 0) rd_first = cyc;
                rd_last = cyc;
                rd_n++;
            end
            if (m_valid) begin
                if (v_n == 0) v_first = cyc;
                v_last = cyc;
                v_n++;
            end
            @(negedge clk);
        end
        check("burst_rd_n", rd_n, 32'd8);
        check("burst_rd_span", rd_last - rd_first, 32'd7);
        check("burst_out_n", v_n, 32'd8);
        check("burst_out_span", v_last - v_first, 32'd7);
        tick(1);
        wait_drain("burst_drain", 20);
        check("burst_rd_count", {16'd0, rd_count}, 32'd8);

        // Eight words with m_ready toggling
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) load(W'(16'h0100 + i), 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_ready = i[0];
            tick(1);
        end
        m_ready = 1'b1;
        wait_drain("toggle_drain", 20);
        check("toggle_rd_count", {16'd0, rd_count}, 32'd8);

        // Stall: only two reads may be outstanding
        enable  = 1'b0;
        m_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) load(W'(16'h4000 + i), 1'b1);
        base = rd_pulses;
        enable = 1'b1;
        tick(10);
        check("stall_rd_pulses", rd_pulses - base, 32'd2);
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_head", {16'd0, m_data}, 32'h4000);
        m_ready = 1'b1;
        wait_drain("stall_drain", 30);
        check("stall_rd_count", {16'd0, rd_count}, 32'd4);

        // Forced underflow drops the word and sets the sticky flag
        enable = 1'b0;
        do_reset();
        load(16'h5A5A, 1'b0);
        load(16'h5B5B, 1'b1);
        enable = 1'b1;
        wait_rd_en("uf_rd_seen");
        uf_next = 1'b1;
        tick(1);
        uf_next = 1'b0;
        wait_drain("uf_drain", 20);
        check("uf_err_set", {31'd0, err_underflow}, 32'd1);
        check("uf_rd_count", {16'd0, rd_count}, 32'd1);
        load(16'h5C5C, 1'b1);
        tick(2);
        wait_drain("uf_drain2", 20);
        check("uf_err_sticky", {31'd0, err_underflow}, 32'd1);
        check("uf_rd_count2", {16'd0, rd_count}, 32'd2);
        do_reset();
        check("uf_err_cleared", {31'd0, err_underflow}, 32'd0);

        // Reset mid-operation with a full skid
        enable  = 1'b0;
        m_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) load(W'(16'h6000 + i), 1'b1);
        enable = 1'b1;
        tick(5);
        m_ready = 1'b0;
        tick(5);
        check("mid_skid_full", {31'd0, m_valid}, 32'd1);
        check("mid_count_nz", {31'd0, (rd_count != '0)}, 32'd1);
        rst = 1'b1;
        clr = 1'b1;
        exp_q.delete();
        tick(1);
        check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_count", {16'd0, rd_count}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;
        clr = 1'b0;
        m_ready = 1'b1;
        tick(8);
        check("mid_no_stale", {31'd0, m_valid}, 32'd0);
        check("mid_count_after", {16'd0, rd_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
